// File: rtl/xm_mem_interface.sv
// Bridges a single-cycle controller memory request onto a 16-bit ack-handshaked bus.
// Latches the request, drives byte lanes, waits for ack or timeout, then pulses memWr_o.
module xm_mem_interface #(
  parameter int unsigned WORD    = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] adr_i,
  input  logic [WORD-1:0] wdata_i,
  output logic            memBusy_o,
  output logic            memWr_o,
  output logic [WORD-1:0] rdata_o,
  output logic            memErr_o,
  input  logic            errClr_i,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [WORD-1:0] bus_adr_o,
  output logic [1:0]      bus_be_o,
  output logic [WORD-1:0] bus_wdata_o,
  input  logic [WORD-1:0] bus_rdata_i,
  input  logic            bus_ack_i
);

  localparam int unsigned HALF  = WORD / 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               byte_q, lane_q;
  logic               accept_c, ack_hit_c, tmo_hit_c, set_err_c;
  logic [1:0]         be_c;
  logic [WORD-1:0]    wdata_c, rd_sel_c;

  // Next state plus request decode and lane steering
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    ack_hit_c = 1'b0;
    tmo_hit_c = 1'b0;
    be_c      = 2'b11;
    wdata_c   = wdata_i;
    rd_sel_c  = bus_rdata_i;

    case (state_q)
      IDLE: begin
        if (memEn_i) begin
          accept_c = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus_ack_i) begin
          ack_hit_c = 1'b1;
          state_d   = DONE;
        end else if (CNT_W'(cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          tmo_hit_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (byteOp_i) begin
      be_c    = adr_i[0] ? 2'b10 : 2'b01;
      wdata_c = adr_i[0] ? {wdata_i[HALF-1:0], HALF'(0)} : {HALF'(0), wdata_i[HALF-1:0]};
    end

    if (byte_q) begin
      rd_sel_c = lane_q ? {HALF'(0), bus_rdata_i[WORD-1:HALF]}
                        : {HALF'(0), bus_rdata_i[HALF-1:0]};
    end

    // Misaligned word access is flagged at accept; the access still goes out
    set_err_c = tmo_hit_c | (accept_c & ~byteOp_i & adr_i[0]);
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and latched request fields
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt_q       <= '0;
      byte_q      <= 1'b0;
      lane_q      <= 1'b0;
      memBusy_o   <= 1'b0;
      memWr_o     <= 1'b0;
      rdata_o     <= '0;
      memErr_o    <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_adr_o   <= '0;
      bus_be_o    <= 2'b00;
      bus_wdata_o <= '0;
    end else begin
      memBusy_o <= (state_d == REQ);
      bus_req_o <= (state_d == REQ);
      memWr_o   <= (state_d == DONE);

      if (accept_c) begin
        cnt_q       <= '0;
        byte_q      <= byteOp_i;
        lane_q      <= adr_i[0];
        bus_we_o    <= memRW_i;
        bus_adr_o   <= {adr_i[WORD-1:1], 1'b0};
        bus_be_o    <= be_c;
        bus_wdata_o <= wdata_c;
      end else if (state_q == REQ) begin
        cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
        if (state_d != REQ) begin
          bus_we_o    <= 1'b0;
          bus_adr_o   <= '0;
          bus_be_o    <= 2'b00;
          bus_wdata_o <= '0;
        end
      end

      if (ack_hit_c) begin
        rdata_o <= bus_we_o ? '0 : rd_sel_c;
      end else if (tmo_hit_c) begin
        rdata_o <= '0;
      end

      // A new error in the same cycle as a clear keeps the flag set
      if (set_err_c) begin
        memErr_o <= 1'b1;
      end else if (errClr_i) begin
        memErr_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xm_mem_interface.sv
// Self-checking bench for xm_mem_interface: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_xm_mem_interface;

  localparam int unsigned WORD    = 16;
  localparam int unsigned TIMEOUT = 15;

  logic            clk_i = 1'b0;
  logic            arst_i;
  logic            memEn_i, memRW_i, byteOp_i, errClr_i;
  logic [WORD-1:0] adr_i, wdata_i;
  logic            memBusy_o, memWr_o, memErr_o;
  logic [WORD-1:0] rdata_o;
  logic            bus_req_o, bus_we_o;
  logic [WORD-1:0] bus_adr_o, bus_wdata_o;
  logic [1:0]      bus_be_o;
  logic [WORD-1:0] bus_rdata_i;
  logic            bus_ack_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit err_m   = 1'b0;

  xm_mem_interface #(.WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .memEn_i     (memEn_i),
    .memRW_i     (memRW_i),
    .byteOp_i    (byteOp_i),
    .adr_i       (adr_i),
    .wdata_i     (wdata_i),
    .memBusy_o   (memBusy_o),
    .memWr_o     (memWr_o),
    .rdata_o     (rdata_o),
    .memErr_o    (memErr_o),
    .errClr_i    (errClr_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_adr_o   (bus_adr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One controller request; delay >= TIMEOUT means the bus never acks
  task automatic run_txn(input bit rw, input bit bop, input logic [15:0] adr,
                         input logic [15:0] wdata, input logic [15:0] rd,
                         input int delay, input bit extra, input bit clr);
    logic [15:0] e_adr, e_wd, e_rd;
    logic [1:0]  e_be;
    bit          tmo, done;
    int          reqcnt;
    e_adr  = adr & 16'hFFFE;
    e_be   = bop ? 2'(2'b01 << adr[0]) : 2'b11;
    e_wd   = bop ? 16'((wdata & 16'h00FF) << (8 * adr[0])) : wdata;
    e_rd   = bop ? 16'((rd >> (8 * adr[0])) & 16'h00FF) : rd;
    tmo    = (delay >= int'(TIMEOUT));
    done   = 1'b0;
    reqcnt = 0;
    if (!bop && adr[0]) err_m = 1'b1;

    @(negedge clk_i);
    memEn_i = 1'b1; memRW_i = rw; byteOp_i = bop; adr_i = adr; wdata_i = wdata;
    errClr_i = clr;
    @(negedge clk_i);
    memEn_i  = 1'b0;
    errClr_i = 1'b0;
    if (extra) begin
      memEn_i = 1'b1; memRW_i = ~rw; byteOp_i = ~bop; adr_i = ~adr; wdata_i = ~wdata;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk_i);
      if (c == 1) memEn_i = 1'b0;
      bus_ack_i = 1'b0;
      if (memWr_o) begin
        done = 1'b1;
      end else begin
        check_eq("busy_in_req", memBusy_o, 1'b1);
        check_eq("req_in_req", bus_req_o, 1'b1);
        check_eq("bus_adr", bus_adr_o, e_adr);
        check_eq("bus_be", bus_be_o, e_be);
        check_eq("bus_we", bus_we_o, rw);
        if (rw) check_eq("bus_wdata", bus_wdata_o, e_wd);
        reqcnt++;
        if (reqcnt == delay + 1) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = rd;
        end else begin
          bus_rdata_i = 16'($urandom);
        end
      end
    end
    bus_ack_i = 1'b0;
    if (tmo) err_m = 1'b1;
    check_eq("completed", done, 1'b1);
    check_eq("req_cycles", reqcnt, tmo ? TIMEOUT : 32'(delay + 1));
    check_eq("busy_done", memBusy_o, 1'b0);
    check_eq("req_done", bus_req_o, 1'b0);
    check_eq("be_done", bus_be_o, 2'b00);
    check_eq("err", memErr_o, err_m);
    if (!rw) check_eq("rdata", rdata_o, tmo ? 16'h0000 : e_rd);
    @(negedge clk_i);
    check_eq("wr_pulse", memWr_o, 1'b0);
    check_eq("adr_idle", bus_adr_o, 16'h0000);
  endtask

  task automatic clear_err();
    @(negedge clk_i);
    errClr_i = 1'b1;
    @(negedge clk_i);
    errClr_i = 1'b0;
    err_m    = 1'b0;
    check_eq("err_clr", memErr_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_i = 1'b0; memEn_i = 1'b0; memRW_i = 1'b0; byteOp_i = 1'b0; errClr_i = 1'b0;
    adr_i = '0; wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
    #12;
    check_eq("rst_busy", memBusy_o, 1'b0);
    check_eq("rst_req", bus_req_o, 1'b0);
    check_eq("rst_err", memErr_o, 1'b0);
    check_eq("rst_rdata", rdata_o, 16'h0000);
    @(negedge clk_i);
    arst_i = 1'b1;

    // Ack outside a transaction must be ignored
    @(negedge clk_i);
    bus_ack_i = 1'b1; bus_rdata_i = 16'hFFFF;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    check_eq("idle_ack_wr", memWr_o, 1'b0);
    check_eq("idle_ack_busy", memBusy_o, 1'b0);
    check_eq("idle_ack_rdata", rdata_o, 16'h0000);

    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b0);
    run_txn(1'b1, 1'b1, 16'h0203, 16'h00A5, 16'h0000, 1, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0201, 16'h0000, 16'h12F0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 16'h0200, 16'h0000, 16'h12F0, 2, 1'b0, 1'b0);
    run_txn(1'b0, 1'b0, 16'h0300, 16'h0000, 16'h1234, TIMEOUT, 1'b0, 1'b0);
    clear_err();
    run_txn(1'b0, 1'b0, 16'h0101, 16'h0000, 16'h5A5A, 2, 1'b1, 1'b0);
    clear_err();
    run_txn(1'b0, 1'b0, 16'h0400, 16'h0000, 16'hC0DE, TIMEOUT - 1, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0501, 16'h7777, 16'h0000, 1, 1'b0, 1'b1);
    clear_err();

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 2) == 0) clear_err();
    end

    // Asynchronous reset in the middle of a request
    @(negedge clk_i);
    memEn_i = 1'b1; memRW_i = 1'b0; byteOp_i = 1'b0; adr_i = 16'h0601;
    @(negedge clk_i);
    memEn_i = 1'b0;
    @(negedge clk_i);
    check_eq("pre_rst_req", bus_req_o, 1'b1);
    #2 arst_i = 1'b0;
    #1;
    err_m = 1'b0;
    check_eq("arst_req", bus_req_o, 1'b0);
    check_eq("arst_busy", memBusy_o, 1'b0);
    check_eq("arst_err", memErr_o, 1'b0);
    check_eq("arst_adr", bus_adr_o, 16'h0000);
    @(negedge clk_i);
    arst_i = 1'b1;
    run_txn(1'b0, 1'b0, 16'h0700, 16'h0000, 16'hA1B2, 4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
